// File: rtl/issue_stage.sv
// Purpose : single-entry decode/issue slot feeding a registered execute stage;
//           holds one decoded instruction until both source operands are valid.
// Latency : accept at edge N, operands valid in cycle N+1 -> out_valid after edge N+1.
// Backpr. : in_ready drops while the slot is occupied and cannot issue; output
//           register holds all fields stable while out_valid && !out_ready.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid/in_ready        decoder handshake; in_pc, in_rs1/2, in_use_rs1/2,
//                            in_rd, in_wen, in_ctrl carry the decoded instruction
//   rs1, rs2                 source indices presented to the register file
//   rs1/2_valid, rs1/2_data  operand availability and value from register file
//   flush                    kill both the slot and the output register
//   out_valid/out_ready      execute handshake; out_pc, out_src1/2, out_rd,
//                            out_wen, out_ctrl are the registered instruction
//   stall_cnt                saturating count of operand-hazard cycles
module issue_stage #(
  parameter int CTRL_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_pc,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic [4:0]        in_rd,
  input  logic              in_wen,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  input  logic              rs1_valid,
  input  logic              rs2_valid,
  input  logic [63:0]       rs1_data,
  input  logic [63:0]       rs2_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_pc,
  output logic [63:0]       out_src1,
  output logic [63:0]       out_src2,
  output logic [4:0]        out_rd,
  output logic              out_wen,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [31:0]       stall_cnt
);

  // Registered occupancy of the ID slot. WAIT and BLOCKED are both S_FULL;
  // which of the two applies is decided each cycle by the operand/output status.
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_t;

  slot_state_t r_slot_state;
  slot_state_t w_slot_next;

  // ID slot fields
  logic [63:0]       r_id_pc;
  logic [4:0]        r_id_rs1;
  logic [4:0]        r_id_rs2;
  logic              r_id_use_rs1;
  logic              r_id_use_rs2;
  logic [4:0]        r_id_rd;
  logic              r_id_wen;
  logic [CTRL_W-1:0] r_id_ctrl;

  // Output pipeline register
  logic              r_out_valid;
  logic [63:0]       r_out_pc;
  logic [63:0]       r_out_src1;
  logic [63:0]       r_out_src2;
  logic [4:0]        r_out_rd;
  logic              r_out_wen;
  logic [CTRL_W-1:0] r_out_ctrl;

  logic [31:0]       r_stall_cnt;

  logic w_id_valid;
  logic w_ops_ok;
  logic w_out_free;
  logic w_fire;
  logic w_accept;
  logic w_hazard;

  assign w_id_valid = (r_slot_state == S_FULL);

  // Unused sources present index 0, which the register file always reports
  // valid, so they can never cause a stall. Driven from slot state only.
  assign rs1 = (w_id_valid && r_id_use_rs1) ? r_id_rs1 : 5'd0;
  assign rs2 = (w_id_valid && r_id_use_rs2) ? r_id_rs2 : 5'd0;

  assign w_ops_ok   = w_id_valid && rs1_valid && rs2_valid;
  assign w_out_free = !r_out_valid || out_ready;
  assign w_fire     = w_ops_ok && w_out_free && !flush;
  assign in_ready   = !flush && (!w_id_valid || w_fire);
  assign w_accept   = in_valid && in_ready;
  assign w_hazard   = w_id_valid && !(rs1_valid && rs2_valid) && !flush;

  // Slot next-state: flush wins, a same-cycle accept refills on fire.
  always_comb begin
    w_slot_next = r_slot_state;
    if (flush) begin
      w_slot_next = S_EMPTY;
    end else if (w_accept) begin
      w_slot_next = S_FULL;
    end else if (w_fire) begin
      w_slot_next = S_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot_state <= S_EMPTY;
    end else begin
      r_slot_state <= w_slot_next;
    end
  end

  // Slot payload captured only on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id_pc      <= 64'd0;
      r_id_rs1     <= 5'd0;
      r_id_rs2     <= 5'd0;
      r_id_use_rs1 <= 1'b0;
      r_id_use_rs2 <= 1'b0;
      r_id_rd      <= 5'd0;
      r_id_wen     <= 1'b0;
      r_id_ctrl    <= '0;
    end else if (w_accept) begin
      r_id_pc      <= in_pc;
      r_id_rs1     <= in_rs1;
      r_id_rs2     <= in_rs2;
      r_id_use_rs1 <= in_use_rs1;
      r_id_use_rs2 <= in_use_rs2;
      r_id_rd      <= in_rd;
      r_id_wen     <= in_wen;
      r_id_ctrl    <= in_ctrl;
    end
  end

  // Output register. Operands are sampled on the fire edge so a forwarded
  // value arriving in that cycle is the one that reaches execute.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= 64'd0;
      r_out_src1  <= 64'd0;
      r_out_src2  <= 64'd0;
      r_out_rd    <= 5'd0;
      r_out_wen   <= 1'b0;
      r_out_ctrl  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_out_pc    <= r_id_pc;
      r_out_src1  <= rs1_data;
      r_out_src2  <= rs2_data;
      r_out_rd    <= r_id_rd;
      r_out_wen   <= r_id_wen;
      r_out_ctrl  <= r_id_ctrl;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Saturating hazard counter; cleared by reset only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= 32'd0;
    end else if (w_hazard && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_pc    = r_out_pc;
  assign out_src1  = r_out_src1;
  assign out_src2  = r_out_src2;
  assign out_rd    = r_out_rd;
  assign out_wen   = r_out_wen;
  assign out_ctrl  = r_out_ctrl;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_issue_stage.sv
// Purpose : directed + random stimulus for issue_stage against a transaction model.
// Latency : n/a (testbench).
// Backpr. : drives out_ready/flush/operand validity randomly and directly.
module tb_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, in_ready;
  logic [63:0] in_pc;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use_rs1, in_use_rs2, in_wen;
  logic [31:0] in_ctrl;
  logic [4:0]  rs1, rs2;
  logic        rs1_valid, rs2_valid;
  logic [63:0] rs1_data, rs2_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [63:0] out_pc, out_src1, out_src2;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [31:0] out_ctrl;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  issue_stage #(.CTRL_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd(in_rd), .in_wen(in_wen), .in_ctrl(in_ctrl),
    .rs1(rs1), .rs2(rs2), .rs1_valid(rs1_valid), .rs2_valid(rs2_valid),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_src1(out_src1), .out_src2(out_src2), .out_rd(out_rd), .out_wen(out_wen),
    .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Register-file behaviour for nonzero indices; index 0 is always valid/zero.
  logic        rf_v1, rf_v2;
  logic [63:0] rf_d1, rf_d2;

  // Transaction model: one instruction waiting in ID, one held toward execute.
  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, wen;
    logic [31:0] ctrl;
  } inst_t;

  typedef struct {
    logic [63:0] pc, s1, s2;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] ctrl;
  } issued_t;

  logic        m_id_v, m_o_v;
  inst_t       m_id;
  issued_t     m_o;
  logic [31:0] m_stall;

  logic        obs_in_ready;
  logic [4:0]  obs_rs2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [63:0] pc, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                       input logic wen, input logic [31:0] ctrl);
    in_valid = 1'b1; in_pc = pc; in_rs1 = r1; in_use_rs1 = u1;
    in_rs2 = r2; in_use_rs2 = u2; in_rd = rd; in_wen = wen; in_ctrl = ctrl;
  endtask

  // One clock cycle: answer the register-file lookup, check, advance the model.
  // Entered and left at a falling edge.
  task automatic cycle();
    logic [4:0] e1, e2;
    logic ok, room, mv, rdy, acc, haz;
    e1 = (m_id_v && m_id.u1) ? m_id.rs1 : 5'd0;
    e2 = (m_id_v && m_id.u2) ? m_id.rs2 : 5'd0;
    rs1_valid = (e1 == 5'd0) ? 1'b1 : rf_v1;
    rs1_data  = (e1 == 5'd0) ? 64'd0 : rf_d1;
    rs2_valid = (e2 == 5'd0) ? 1'b1 : rf_v2;
    rs2_data  = (e2 == 5'd0) ? 64'd0 : rf_d2;
    #1;
    ok   = m_id_v && rs1_valid && rs2_valid;
    room = !m_o_v || out_ready;
    mv   = ok && room && !flush;
    rdy  = !flush && (!m_id_v || mv);
    acc  = in_valid && rdy;
    haz  = m_id_v && !(rs1_valid && rs2_valid) && !flush;
    obs_in_ready = in_ready;
    obs_rs2      = rs2;
    chk("in_ready", in_ready, rdy);
    chk("rs1", rs1, e1);
    chk("rs2", rs2, e2);
    chk("out_valid", out_valid, m_o_v);
    chk("stall_cnt", stall_cnt, m_stall);
    if (m_o_v) begin
      chk("out_pc", out_pc, m_o.pc);
      chk("out_src1", out_src1, m_o.s1);
      chk("out_src2", out_src2, m_o.s2);
      chk("out_rd", out_rd, m_o.rd);
      chk("out_wen", out_wen, m_o.wen);
      chk("out_ctrl", out_ctrl, m_o.ctrl);
    end
    if (flush) begin
      m_id_v = 1'b0;
      m_o_v  = 1'b0;
    end else begin
      if (haz && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (mv) begin
        m_o.pc = m_id.pc; m_o.s1 = rs1_data; m_o.s2 = rs2_data;
        m_o.rd = m_id.rd; m_o.wen = m_id.wen; m_o.ctrl = m_id.ctrl;
        m_o_v = 1'b1;
      end else if (m_o_v && out_ready) begin
        m_o_v = 1'b0;
      end
      if (acc) begin
        m_id.pc = in_pc; m_id.rs1 = in_rs1; m_id.rs2 = in_rs2; m_id.rd = in_rd;
        m_id.u1 = in_use_rs1; m_id.u2 = in_use_rs2; m_id.wen = in_wen; m_id.ctrl = in_ctrl;
        m_id_v = 1'b1;
      end else if (mv) begin
        m_id_v = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_use_rs1 = 1'b0; in_use_rs2 = 1'b0;
    in_rd = '0; in_wen = 1'b0; in_ctrl = '0;
    rs1_valid = 1'b1; rs2_valid = 1'b1; rs1_data = '0; rs2_data = '0;
    rf_v1 = 1'b1; rf_v2 = 1'b1; rf_d1 = '0; rf_d2 = '0;
    m_id_v = 1'b0; m_o_v = 1'b0; m_stall = 32'd0;
    m_o.pc = '0; m_o.s1 = '0; m_o.s2 = '0; m_o.rd = '0; m_o.wen = 1'b0; m_o.ctrl = '0;
    m_id.pc = '0; m_id.rs1 = '0; m_id.rs2 = '0; m_id.rd = '0;
    m_id.u1 = 1'b0; m_id.u2 = 1'b0; m_id.wen = 1'b0; m_id.ctrl = '0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_rs1", rs1, 5'd0);
    chk("rst_rs2", rs2, 5'd0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_src1", out_src1, 64'd0);
    chk("rst_out_ctrl", out_ctrl, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [63:0] d_a, d_b, d_c;

    do_reset();

    // Back-to-back independent instructions
    out_ready = 1'b1; rf_v1 = 1'b1; rf_v2 = 1'b1;
    offer(64'h8000_0000, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 32'hA0);
    cycle();
    chk("b2b_first_ov", out_valid, 1'b0);
    d_a = {$urandom, $urandom}; rf_d1 = d_a; rf_d2 = ~d_a;
    offer(64'h8000_0004, 5'd4, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 32'hA1);
    cycle();
    chk("b2b_pc0", out_pc, 64'h8000_0000);
    chk("b2b_src1_0", out_src1, d_a);
    d_b = {$urandom, $urandom}; rf_d1 = d_b;
    offer(64'h8000_0008, 5'd7, 1'b1, 5'd8, 1'b1, 5'd9, 1'b0, 32'hA2);
    cycle();
    chk("b2b_pc1", out_pc, 64'h8000_0004);
    chk("b2b_src1_1", out_src1, d_b);
    d_c = {$urandom, $urandom}; rf_d1 = d_c;
    in_valid = 1'b0;
    cycle();
    chk("b2b_pc2", out_pc, 64'h8000_0008);
    chk("b2b_src1_2", out_src1, d_c);
    chk("b2b_ov2", out_valid, 1'b1);
    cycle();
    chk("b2b_drained", out_valid, 1'b0);
    chk("b2b_stall", stall_cnt, 32'd0);

    // RAW hazard on rs1 for three cycles
    do_reset();
    out_ready = 1'b1; rf_v1 = 1'b0; rf_d1 = 64'hDEAD_BEEF_DEAD_BEEF;
    offer(64'h8000_0010, 5'd3, 1'b1, 5'd4, 1'b0, 5'd1, 1'b1, 32'hB0);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("raw_wait_ready", obs_in_ready, 1'b0);
      chk("raw_wait_ov", out_valid, 1'b0);
    end
    rf_v1 = 1'b1; rf_d1 = 64'h1234;
    cycle();
    chk("raw_ov", out_valid, 1'b1);
    chk("raw_src1", out_src1, 64'h1234);
    chk("raw_pc", out_pc, 64'h8000_0010);
    chk("raw_stall", stall_cnt, 32'd3);

    // Backpressure: two instructions, out_ready low for four cycles
    do_reset();
    out_ready = 1'b0; rf_v1 = 1'b1; rf_v2 = 1'b1;
    rf_d1 = 64'h1111; rf_d2 = 64'h2222;
    offer(64'h8000_0200, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 32'hC0);
    cycle();
    rf_d1 = 64'h3333; rf_d2 = 64'h4444;
    offer(64'h8000_0204, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 32'hC1);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("bp_in_ready", obs_in_ready, 1'b0);
      chk("bp_hold_pc", out_pc, 64'h8000_0200);
      chk("bp_hold_src1", out_src1, 64'h3333);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_second_pc", out_pc, 64'h8000_0204);
    chk("bp_second_ov", out_valid, 1'b1);
    cycle();
    chk("bp_drained", out_valid, 1'b0);

    // Flush while both registers are occupied
    do_reset();
    out_ready = 1'b0;
    offer(64'h8000_0300, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 32'hD0);
    cycle();
    offer(64'h8000_0304, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 32'hD1);
    cycle();
    offer(64'h8000_0308, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 32'hD2);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_ov", out_valid, 1'b0);
    out_ready = 1'b1;
    offer(64'h8000_0100, 5'd6, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 32'hD3);
    cycle();
    chk("flush_in_ready", obs_in_ready, 1'b1);
    in_valid = 1'b0;
    cycle();
    chk("flush_next_ov", out_valid, 1'b1);
    chk("flush_next_pc", out_pc, 64'h8000_0100);

    // Unused rs2 while x5 is not available
    do_reset();
    out_ready = 1'b1; rf_v1 = 1'b1; rf_v2 = 1'b0;
    offer(64'h8000_0400, 5'd2, 1'b1, 5'd5, 1'b0, 5'd9, 1'b1, 32'hE0);
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("unused_rs2", obs_rs2, 5'd0);
    chk("unused_ov", out_valid, 1'b1);
    chk("unused_stall", stall_cnt, 32'd0);

    // Asynchronous reset in the middle of a stall
    do_reset();
    out_ready = 1'b0; rf_v1 = 1'b0; rf_v2 = 1'b1;
    offer(64'h8000_0500, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 32'hF0);
    cycle();
    offer(64'h8000_0504, 5'd7, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 32'hF1);
    cycle();
    in_valid = 1'b0;
    repeat (7) cycle();
    chk("arst_pre_stall", stall_cnt, 32'd7);
    chk("arst_pre_ov", out_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_ov", out_valid, 1'b0);
    chk("arst_stall", stall_cnt, 32'd0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_rs1", rs1, 5'd0);
    chk("arst_out_pc", out_pc, 64'd0);
    do_reset();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      in_valid   = ($urandom_range(0, 9) < 6);
      in_pc      = {32'h8000_0000, $urandom} & ~64'h3;
      in_rs1     = 5'($urandom_range(0, 31));
      in_rs2     = 5'($urandom_range(0, 31));
      in_use_rs1 = 1'($urandom_range(0, 1));
      in_use_rs2 = 1'($urandom_range(0, 1));
      in_rd      = 5'($urandom_range(0, 31));
      in_wen     = 1'($urandom_range(0, 1));
      in_ctrl    = $urandom;
      rf_v1      = ($urandom_range(0, 9) < 7);
      rf_v2      = ($urandom_range(0, 9) < 7);
      rf_d1      = {$urandom, $urandom};
      rf_d2      = {$urandom, $urandom};
      out_ready  = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 24) == 0);
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
